// File: rtl/vdp_sdram_initiator_pkg.sv
// Shared types and constants for the VDP SDRAM bus initiator and its refresh timer.
package vdp_sdram_initiator_pkg;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_WORD_W = 16;
  localparam logic [SDRAM_WORD_W-1:0] SDRAM_TIMEOUT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD,
    ST_REFRESH
  } sdram_init_state_t;

  function automatic logic [7:0] select_byte(input logic [SDRAM_WORD_W-1:0] word,
                                             input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/vdp_sdram_refresh_timer.sv
// Free-running refresh interval counter with a saturating one-deep pending flag.
module vdp_sdram_refresh_timer #(
  parameter int REFRESH_INTERVAL = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clear_i,
  output logic pending_o
);

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);

  logic [CNT_W-1:0] count_q;
  logic             pending_q;
  logic             tick;

  assign tick      = en_i && (count_q == CNT_W'(REFRESH_INTERVAL - 1));
  assign pending_o = pending_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      if (en_i) begin
        count_q <= tick ? '0 : count_q + CNT_W'(1);
      end
      // A tick landing on the clear cycle keeps the flag set.
      pending_q <= tick | (pending_q & ~clear_i);
    end
  end

endmodule

// File: rtl/vdp_sdram_initiator.sv
// Single-client byte initiator for ip_sdram with self-scheduled refresh and timeout.
// Optional one-word read cache enabled by defining SDRAM_INITIATOR_WORD_CACHE_EN.
module vdp_sdram_initiator
  import vdp_sdram_initiator_pkg::*;
#(
  parameter int REFRESH_INTERVAL = 1024,
  parameter int TIMEOUT_COUNT    = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [SDRAM_ADDR_W-1:0] req_address,
  input  logic [7:0]              req_wdata,
  output logic                    rsp_valid,
  output logic [7:0]              rsp_rdata,
  output logic [SDRAM_WORD_W-1:0] rsp_word,
  output logic                    error,
  input  logic                    sdram_init_busy,
  output logic [SDRAM_ADDR_W-1:0] bus_address,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic                    bus_write,
  output logic                    bus_refresh,
  output logic [7:0]              bus_wdata,
  input  logic [SDRAM_WORD_W-1:0] bus_rdata,
  input  logic                    bus_rdata_en
);

  localparam int TMO_W = $clog2(TIMEOUT_COUNT + 1);

  sdram_init_state_t       state_q;
  logic [SDRAM_ADDR_W-1:0] addr_q;
  logic                    write_q;
  logic [7:0]              wdata_q;
  logic                    bus_valid_q;
  logic                    bus_write_q;
  logic                    bus_refresh_q;
  logic                    rsp_valid_q;
  logic [7:0]              rsp_rdata_q;
  logic [SDRAM_WORD_W-1:0] rsp_word_q;
  logic                    error_q;
  logic [TMO_W-1:0]        tmo_q;

  logic                    refresh_pending;
  logic                    refresh_clear;
  logic                    client_accept;
  logic                    busy_state;
  logic                    done;
  logic                    tmo_hit;
  logic                    timeout_fire;
  logic                    read_hit;
  logic [SDRAM_WORD_W-1:0] hit_word;

  assign req_ready   = (state_q == ST_IDLE) && !refresh_pending;
  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;
  assign bus_valid   = bus_valid_q;
  assign bus_write   = bus_write_q;
  assign bus_refresh = bus_refresh_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_word    = rsp_word_q;
  assign error       = error_q;

  assign client_accept = req_ready && req_valid;
  assign busy_state    = (state_q == ST_REQ) || (state_q == ST_WAIT_RD) || (state_q == ST_REFRESH);
  assign done          = (state_q == ST_WAIT_RD) ? bus_rdata_en : bus_ready;
  assign tmo_hit       = (tmo_q == TMO_W'(TIMEOUT_COUNT - 1));
  assign timeout_fire  = busy_state && !done && tmo_hit;
  assign refresh_clear = (state_q == ST_REFRESH) && bus_ready;

  vdp_sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q != ST_INIT),
    .clear_i  (refresh_clear),
    .pending_o(refresh_pending)
  );

`ifdef SDRAM_INITIATOR_WORD_CACHE_EN
  logic                    cache_valid_q;
  logic [21:0]             cache_tag_q;
  logic [SDRAM_WORD_W-1:0] cache_word_q;
  logic                    tag_match;

  assign tag_match = cache_valid_q && (cache_tag_q == req_address[22:1]);
  assign read_hit  = tag_match && !req_write;
  assign hit_word  = cache_word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_word_q  <= '0;
    end else if (timeout_fire) begin
      cache_valid_q <= 1'b0;
    end else if ((state_q == ST_WAIT_RD) && bus_rdata_en) begin
      cache_valid_q <= 1'b1;
      cache_tag_q   <= addr_q[22:1];
      cache_word_q  <= bus_rdata;
    end else if (client_accept && req_write && tag_match) begin
      if (req_address[0]) cache_word_q[15:8] <= req_wdata;
      else                cache_word_q[7:0]  <= req_wdata;
    end
  end
`else
  assign read_hit = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_INIT;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      bus_valid_q   <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_refresh_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_word_q    <= '0;
      error_q       <= 1'b0;
      tmo_q         <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (busy_state && !done && !tmo_hit) tmo_q <= tmo_q + TMO_W'(1);

      if (timeout_fire) begin
        error_q       <= 1'b1;
        bus_valid_q   <= 1'b0;
        bus_refresh_q <= 1'b0;
        state_q       <= ST_IDLE;
        // An abandoned read still owes the client exactly one response.
        if (state_q == ST_WAIT_RD || (state_q == ST_REQ && !write_q)) begin
          rsp_valid_q <= 1'b1;
          rsp_word_q  <= SDRAM_TIMEOUT_WORD;
          rsp_rdata_q <= SDRAM_TIMEOUT_WORD[7:0];
        end
      end else begin
        case (state_q)
          ST_INIT: begin
            if (!sdram_init_busy) state_q <= ST_IDLE;
          end
          ST_IDLE: begin
            if (refresh_pending) begin
              state_q       <= ST_REFRESH;
              bus_valid_q   <= 1'b1;
              bus_refresh_q <= 1'b1;
              bus_write_q   <= 1'b0;
              tmo_q         <= '0;
            end else if (req_valid) begin
              addr_q  <= req_address;
              write_q <= req_write;
              wdata_q <= req_wdata;
              if (read_hit) begin
                rsp_valid_q <= 1'b1;
                rsp_word_q  <= hit_word;
                rsp_rdata_q <= select_byte(hit_word, req_address[0]);
              end else begin
                state_q       <= ST_REQ;
                bus_valid_q   <= 1'b1;
                bus_refresh_q <= 1'b0;
                bus_write_q   <= req_write;
                tmo_q         <= '0;
              end
            end
          end
          ST_REQ: begin
            if (bus_ready) begin
              bus_valid_q <= 1'b0;
              tmo_q       <= '0;
              state_q     <= write_q ? ST_IDLE : ST_WAIT_RD;
            end
          end
          ST_WAIT_RD: begin
            if (bus_rdata_en) begin
              rsp_valid_q <= 1'b1;
              rsp_word_q  <= bus_rdata;
              rsp_rdata_q <= select_byte(bus_rdata, addr_q[0]);
              state_q     <= ST_IDLE;
            end
          end
          ST_REFRESH: begin
            if (bus_ready) begin
              bus_valid_q   <= 1'b0;
              bus_refresh_q <= 1'b0;
              state_q       <= ST_IDLE;
            end
          end
          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vdp_sdram_initiator.sv
// Directed bench for vdp_sdram_initiator with a small behavioural ip_sdram stub.
module tb_vdp_sdram_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [22:0] req_address;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] rsp_word;
  logic        error;
  logic        sdram_init_busy;
  logic [22:0] bus_address;
  logic        bus_valid;
  logic        bus_ready = 1'b0;
  logic        bus_write;
  logic        bus_refresh;
  logic [7:0]  bus_wdata;
  logic [15:0] bus_rdata = 16'h0;
  logic        bus_rdata_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #6 clk = ~clk;

  vdp_sdram_initiator #(
    .REFRESH_INTERVAL(16),
    .TIMEOUT_COUNT   (50)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_word       (rsp_word),
    .error          (error),
    .sdram_init_busy(sdram_init_busy),
    .bus_address    (bus_address),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_write      (bus_write),
    .bus_refresh    (bus_refresh),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_rdata_en   (bus_rdata_en)
  );

  // Stub controls (written by the main sequence only).
  int stub_ready_delay = 0;
  int stub_rd_latency  = 2;
  bit stub_drop_rd     = 1'b0;

  // Stub internal state (written by the stub process only).
  logic [15:0] mem [16] = '{default: 16'h0};
  int          stub_wait = 0;
  bit          stub_rd_pend = 1'b0;
  int          stub_rd_cnt = 0;
  logic [22:0] stub_rd_addr = '0;

  always @(negedge clk) begin
    bus_rdata_en = 1'b0;
    if (stub_rd_pend) begin
      if (stub_rd_cnt == 0) begin
        bus_rdata_en = 1'b1;
        bus_rdata    = mem[stub_rd_addr[4:1]];
        stub_rd_pend = 1'b0;
      end else begin
        stub_rd_cnt--;
      end
    end
    bus_ready = 1'b0;
    if (bus_valid) begin
      if (stub_wait < stub_ready_delay) begin
        stub_wait++;
      end else begin
        bus_ready = 1'b1;
        stub_wait = 0;
        if (!bus_refresh) begin
          if (bus_write) begin
            if (bus_address[0]) mem[bus_address[4:1]][15:8] = bus_wdata;
            else                mem[bus_address[4:1]][7:0]  = bus_wdata;
          end else if (!stub_drop_rd) begin
            stub_rd_pend = 1'b1;
            stub_rd_cnt  = stub_rd_latency;
            stub_rd_addr = bus_address;
          end
        end
      end
    end else begin
      stub_wait = 0;
    end
  end

  typedef struct packed {
    logic        refresh;
    logic        write;
    logic [22:0] addr;
  } acc_t;
  acc_t acc_log[$];

  always @(posedge clk) begin
    if (bus_valid && bus_ready) acc_log.push_back({bus_refresh, bus_write, bus_address});
  end

  typedef struct {
    bit          wr;
    logic [22:0] addr;
    logic [7:0]  wdata;
    logic [15:0] exp_word;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the handshake edge.
  task automatic client_req(input bit wr, input logic [22:0] a, input logic [7:0] d);
    int n;
    n = 0;
    req_valid   = 1'b1;
    req_write   = wr;
    req_address = a;
    req_wdata   = d;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_wait", req_ready, 1);
      req_valid = 1'b0;
    end else begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) check("rsp_wait", rsp_valid, 1);
  endtask

  task automatic wait_bus_idle();
    int n;
    n = 0;
    while (bus_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bus_idle_wait", bus_valid, 0);
  endtask

  initial begin
    int   n;
    int   bad;
    int   n0;
    logic [15:0] w0;

    vecs[0] = '{1'b1, 23'h000000, 8'h12, 16'h0000, 8'h00};
    vecs[1] = '{1'b1, 23'h000001, 8'h23, 16'h0000, 8'h00};
    vecs[2] = '{1'b0, 23'h000000, 8'h00, 16'h2312, 8'h12};
    vecs[3] = '{1'b0, 23'h000001, 8'h00, 16'h2312, 8'h23};
    vecs[4] = '{1'b1, 23'h000006, 8'hAB, 16'h0000, 8'h00};
    vecs[5] = '{1'b1, 23'h000007, 8'hCD, 16'h0000, 8'h00};
    vecs[6] = '{1'b0, 23'h000007, 8'h00, 16'hCDAB, 8'hCD};
    vecs[7] = '{1'b0, 23'h000006, 8'h00, 16'hCDAB, 8'hAB};

    reset           = 1'b1;
    sdram_init_busy = 1'b1;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_address     = '0;
    req_wdata       = '0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", req_ready, 0);
    check("rst_bus_valid", bus_valid, 0);
    check("rst_bus_write", bus_write, 0);
    check("rst_bus_refresh", bus_refresh, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_error", error, 0);
    check("rst_bus_address", bus_address, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_word", rsp_word, 0);

    // Controller still initialising for 100 clocks.
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready || bus_valid) bad++;
    end
    check("init_hold", bad, 0);
    sdram_init_busy = 1'b0;
    @(negedge clk);
    check("ready_after_init", req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      client_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].wr) begin
        wait_bus_idle();
        check("wr_accept_addr", acc_log[$].addr, vecs[i].addr);
        check("wr_accept_kind", {acc_log[$].refresh, acc_log[$].write}, 2'b01);
        $display("txn %0d write addr=%06h data=%02h", i, vecs[i].addr, vecs[i].wdata);
      end else begin
        wait_rsp(n);
        check("rd_word", rsp_word, vecs[i].exp_word);
        check("rd_byte", rsp_rdata, vecs[i].exp_byte);
        $display("txn %0d read addr=%06h word=%04h byte=%02h", i, vecs[i].addr, rsp_word, rsp_rdata);
        @(negedge clk);
        check("rsp_pulse_width", rsp_valid, 0);
      end
    end

    // Controller stalls bus_ready for 5 clocks.
    stub_ready_delay = 5;
    client_req(1'b1, 23'h000010, 8'h99);
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", bus_valid, 1);
      check("stall_addr", bus_address, 23'h000010);
      @(negedge clk);
    end
    check("stall_drop", bus_valid, 0);
    $display("txn stall write addr=000010 data=99");
    stub_ready_delay = 0;

    // Client request coinciding with a freshly set refresh_pending.
    wait_bus_idle();
    n = 0;
    while (!(!req_ready && !bus_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("pending_seen", req_ready, 0);
    n0 = acc_log.size();
    client_req(1'b1, 23'h00000A, 8'h5A);
    wait_bus_idle();
    if (acc_log.size() < n0 + 2) begin
      check("arb_accept_count", acc_log.size(), n0 + 2);
    end else begin
      check("arb_first_refresh", acc_log[n0].refresh, 1);
      check("arb_second_client", acc_log[n0+1].refresh, 0);
      check("arb_second_addr", acc_log[n0+1].addr, 23'h00000A);
    end
    $display("txn arbitration write addr=00000a data=5a");

    // Read never answered by the controller.
    stub_drop_rd = 1'b1;
    client_req(1'b0, 23'h000004, 8'h00);
    wait_rsp(n);
    check("tmo_latency", n, 51);
    check("tmo_error", error, 1);
    check("tmo_rdata", rsp_rdata, 8'hFF);
    check("tmo_word", rsp_word, 16'hFFFF);
    $display("txn timeout read addr=000004 cycles=%0d", n);
    stub_drop_rd = 1'b0;
    @(negedge clk);
    client_req(1'b1, 23'h000004, 8'h77);
    wait_bus_idle();
    check("post_tmo_write_addr", acc_log[$].addr, 23'h000004);
    check("post_tmo_write_kind", {acc_log[$].refresh, acc_log[$].write}, 2'b01);
    check("error_sticky", error, 1);
    $display("txn post-timeout write addr=000004 data=77");

    // Reset during a read; the late read word must be ignored.
    stub_rd_latency = 8;
    client_req(1'b0, 23'h000000, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_bus_valid", bus_valid, 0);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_error", error, 0);
    check("midrst_rsp_word", rsp_word, 0);
    check("midrst_bus_address", bus_address, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) bad++;
    end
    check("late_rdata_ignored", bad, 0);
    $display("txn reset mid-read addr=000000");
    stub_rd_latency = 2;

`ifdef SDRAM_INITIATOR_WORD_CACHE_EN
    n0 = 0;
    for (int i = 0; i < acc_log.size(); i++) if (!acc_log[i].refresh) n0++;
    client_req(1'b0, 23'h000002, 8'h00);
    wait_rsp(n);
    w0 = rsp_word;
    @(negedge clk);
    client_req(1'b0, 23'h000002, 8'h00);
    wait_rsp(n);
    check("cache_hit_latency", n, 0);
    check("cache_hit_word", rsp_word, w0);
    wait_bus_idle();
    bad = 0;
    for (int i = 0; i < acc_log.size(); i++) if (!acc_log[i].refresh) bad++;
    check("cache_bus_requests", bad - n0, 1);
    $display("txn cache read addr=000002 word=%04h", rsp_word);
`else
    w0 = 16'h0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
